regfile_bypass: RTL

Parametrised register file, the next generation of the processor's 4×8 register file: configurable width, depth and read-port count, with registered reads, optional write-to-read bypass and a per-register busy scoreboard. It sits between decode and the ALU/accumulator path. Decode locks the destination of a multi-cycle operation. Issue reads operands and stalls while a source is still pending. Write-back clears the lock. Read and write may happen in the same cycle, unlike the old read/write-select pin.

---
 rtl/regfile_pkg.sv | 20 ++
 rtl/regfile_scoreboard.sv | 54 +++++
 rtl/regfile_bypass.sv | 88 ++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the parametrised register file with bypass and scoreboard.
package regfile_pkg;

   localparam int unsigned DEF_DATA_W   = 8;
   localparam int unsigned DEF_NUM_REGS = 4;
   localparam int unsigned DEF_NUM_RD   = 2;

   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 0;
      while ((32'd1 << r) < n) r++;
      return r;
   endfunction

   // LSB index of port p inside a packed multi-port bus of w-bit fields
   function automatic int unsigned slice_lsb(input int unsigned p, input int unsigned w);
      return p * w;
   endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard: lock/clear update and per-port read hazard detection.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter  int unsigned NUM_REGS = DEF_NUM_REGS,
   parameter  int unsigned NUM_RD   = DEF_NUM_RD,
   parameter  int unsigned ZERO_REG = 1,
   parameter  int unsigned BYPASS   = 1,
   localparam int unsigned AW       = clog2(NUM_REGS)
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 wr_en,
   input  logic [AW-1:0]        wr_addr,
   input  logic                 lock_en,
   input  logic [AW-1:0]        lock_addr,
   input  logic                 rd_en,
   input  logic [NUM_RD*AW-1:0] rd_addr,
   output logic [NUM_REGS-1:0]  busy,
   output logic                 stall_c
);

   logic [NUM_REGS-1:0] busy_nxt;
   logic [NUM_RD-1:0]   hazard;

   // A lock wins over a same-cycle write-back: the lock names a newer producer.
   always_comb begin
      busy_nxt = busy;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
         if (lock_en && (lock_addr == AW'(i)))
            busy_nxt[i] = 1'b1;
         else if (wr_en && (wr_addr == AW'(i)))
            busy_nxt[i] = 1'b0;
      end
      if (ZERO_REG != 0) busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) busy <= '0;
      else          busy <= busy_nxt;
   end

   always_comb begin
      hazard = '0;
      for (int unsigned p = 0; p < NUM_RD; p++) begin
         logic [AW-1:0] a;
         a = rd_addr[slice_lsb(p, AW) +: AW];
         hazard[p] = busy[a] && !((BYPASS != 0) && wr_en && (wr_addr == a));
      end
   end

   assign stall_c = rd_en && (|hazard);

endmodule

// File: rtl/regfile_bypass.sv
// Multi-port register file with registered reads, optional write-to-read bypass and busy scoreboard.
module regfile_bypass
   import regfile_pkg::*;
#(
   parameter  int unsigned DATA_W   = DEF_DATA_W,
   parameter  int unsigned NUM_REGS = DEF_NUM_REGS,
   parameter  int unsigned NUM_RD   = DEF_NUM_RD,
   parameter  int unsigned ZERO_REG = 1,
   parameter  int unsigned BYPASS   = 1,
   localparam int unsigned AW       = clog2(NUM_REGS)
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     wr_en,
   input  logic [AW-1:0]            wr_addr,
   input  logic [DATA_W-1:0]        wr_data,
   input  logic                     lock_en,
   input  logic [AW-1:0]            lock_addr,
   input  logic                     rd_en,
   input  logic [NUM_RD*AW-1:0]     rd_addr,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   output logic                     rd_valid,
   output logic                     rd_stall,
   output logic [NUM_REGS-1:0]      busy
);

   logic [DATA_W-1:0]        regs [NUM_REGS];
   logic [NUM_RD*DATA_W-1:0] rd_nxt;
   logic                     stall_c;
   logic                     rd_ok;
   logic                     wr_ok;

   regfile_scoreboard #(
      .NUM_REGS (NUM_REGS),
      .NUM_RD   (NUM_RD),
      .ZERO_REG (ZERO_REG),
      .BYPASS   (BYPASS)
   ) u_sb (
      .clk       (clk),
      .reset_n   (reset_n),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .lock_en   (lock_en),
      .lock_addr (lock_addr),
      .rd_en     (rd_en),
      .rd_addr   (rd_addr),
      .busy      (busy),
      .stall_c   (stall_c)
   );

   assign rd_stall = stall_c;
   assign rd_ok    = rd_en && !stall_c;
   assign wr_ok    = wr_en && !((ZERO_REG != 0) && (wr_addr == '0));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else if (wr_ok) begin
         regs[wr_addr] <= wr_data;
      end
   end

   // Per-port source select: hard zero, forwarded write data, or stored value.
   always_comb begin
      rd_nxt = '0;
      for (int unsigned p = 0; p < NUM_RD; p++) begin
         logic [AW-1:0] a;
         a = rd_addr[slice_lsb(p, AW) +: AW];
         if ((ZERO_REG != 0) && (a == '0))
            rd_nxt[slice_lsb(p, DATA_W) +: DATA_W] = '0;
         else if ((BYPASS != 0) && wr_en && (wr_addr == a))
            rd_nxt[slice_lsb(p, DATA_W) +: DATA_W] = wr_data;
         else
            rd_nxt[slice_lsb(p, DATA_W) +: DATA_W] = regs[a];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_data  <= '0;
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= rd_ok;
         if (rd_ok) rd_data <= rd_nxt;
      end
   end

endmodule
